crot_quarter_turn_gate_pipelined: RTL and testbench

//   Controlled rotation by k*pi/2 (k = 0..3, per sample) on one complex fixed-point amplitude.

---
 rtl/crot_quarter_turn_gate_pipelined.sv | 147 ++++++++++++++
 tb/tb_crot_quarter_turn_gate_pipelined.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crot_quarter_turn_gate_pipelined.sv
// Controlled k*pi/2 rotation of one complex amplitude, swap/negate only, valid/ready pipe.
// Optional CROT_SAT_NEG_EN: saturating negation plus sticky sat_flag output.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module crot_quarter_turn_gate_pipelined #(
  parameter int WIDTH   = `TOTAL_WIDTH,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ctrl,
  input  logic [1:0]       k,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] ai,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pr,
  output logic [WIDTH-1:0] pi
`ifdef CROT_SAT_NEG_EN
  ,
  output logic             sat_flag
`endif
);

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg(
    input logic [WIDTH-1:0] x
  );
`ifdef CROT_SAT_NEG_EN
    if (x == MIN_V) return ~MIN_V;
`endif
    return -x;
  endfunction

  logic             en;
  logic [1:0]       ke;
  logic [WIDTH-1:0] s1_re;
  logic [WIDTH-1:0] s1_im;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [WIDTH-1:0]   re_q [LATENCY];
  logic [WIDTH-1:0]   re_d [LATENCY];
  logic [WIDTH-1:0]   im_q [LATENCY];
  logic [WIDTH-1:0]   im_d [LATENCY];

  assign en        = out_ready | ~vld_q[LATENCY-1];
  assign in_ready  = en;
  assign out_valid = vld_q[LATENCY-1];
  assign pr        = re_q[LATENCY-1];
  assign pi        = im_q[LATENCY-1];

  // multiply by i^ke: each step is a swap plus one negation
  always_comb begin
    ke    = ctrl ? k : 2'd0;
    s1_re = ar;
    s1_im = ai;
    unique case (1'b1)
      ke == 2'd0: begin
        s1_re = ar;
        s1_im = ai;
      end
      ke == 2'd1: begin
        s1_re = neg(ai);
        s1_im = ar;
      end
      ke == 2'd2: begin
        s1_re = neg(ar);
        s1_im = neg(ai);
      end
      ke == 2'd3: begin
        s1_re = ai;
        s1_im = neg(ar);
      end
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    re_d  = re_q;
    im_d  = im_q;
    if (en) begin
      vld_d[0] = in_valid & en;
      re_d[0]  = s1_re;
      im_d[0]  = s1_im;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        re_d[i]  = re_q[i-1];
        im_d[i]  = im_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      re_q  <= '{default: '0};
      im_q  <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      re_q  <= re_d;
      im_q  <= im_d;
    end
  end

`ifdef CROT_SAT_NEG_EN
  logic               s1_sat;
  logic [LATENCY-1:0] sat_q;
  logic [LATENCY-1:0] sat_d;
  logic               sat_flag_q;
  logic               sat_flag_d;

  assign sat_flag = sat_flag_q;

  always_comb begin
    s1_sat = ((ke == 2'd1) && (ai == MIN_V)) |
             ((ke == 2'd2) && ((ar == MIN_V) || (ai == MIN_V))) |
             ((ke == 2'd3) && (ar == MIN_V));
    sat_d = sat_q;
    if (en) begin
      sat_d[0] = s1_sat;
      for (int i = 1; i < LATENCY; i++) begin
        sat_d[i] = sat_q[i-1];
      end
    end
    // only samples actually handed downstream count
    sat_flag_d = sat_flag_q |
                 (out_valid & out_ready & sat_q[LATENCY-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q      <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_q      <= sat_d;
      sat_flag_q <= sat_flag_d;
    end
  end
`endif

endmodule

// File: tb/tb_crot_quarter_turn_gate_pipelined.sv
// Bench for crot_quarter_turn_gate_pipelined: directed cases plus random stream
// against a complex-multiply-by-i reference model.
module tb_crot_quarter_turn_gate_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        ctrl = 1'b0;
  logic [1:0]  k = 2'd0;
  logic [15:0] ar = '0;
  logic [15:0] ai = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] pr, pi;
  logic        in_ready1, out_valid1;
  logic [15:0] pr1, pi1;
`ifdef CROT_SAT_NEG_EN
  logic        sat_flag, sat_flag1;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  crot_quarter_turn_gate_pipelined #(.WIDTH(16), .LATENCY(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .k(k), .ar(ar), .ai(ai),
    .out_valid(out_valid), .out_ready(out_ready),
    .pr(pr), .pi(pi)
`ifdef CROT_SAT_NEG_EN
    , .sat_flag(sat_flag)
`endif
  );

  crot_quarter_turn_gate_pipelined #(.WIDTH(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .ctrl(ctrl), .k(k), .ar(ar), .ai(ai),
    .out_valid(out_valid1), .out_ready(out_ready),
    .pr(pr1), .pi(pi1)
`ifdef CROT_SAT_NEG_EN
    , .sat_flag(sat_flag1)
`endif
  );

  // reduce an exact integer result to 16 bits: clamp or wrap
  function automatic logic [16:0] fold(input int v);
`ifdef CROT_SAT_NEG_EN
    if (v > 32767) return {1'b1, 16'h7FFF};
`endif
    return {1'b0, v[15:0]};
  endfunction

  // reference: (a + jb) * j^ke in exact integers, then fold
  function automatic logic [32:0] ref_rot(
    input logic [15:0] a, input logic [15:0] b,
    input logic c, input logic [1:0] kk
  );
    int x, y, t, n;
    logic [16:0] fr, fi;
    x = int'($signed(a));
    y = int'($signed(b));
    n = c ? int'(kk) : 0;
    for (int s = 0; s < n; s++) begin
      t = x;
      x = -y;
      y = t;
    end
    fr = fold(x);
    fi = fold(y);
    return {fr[16] | fi[16], fr[15:0], fi[15:0]};
  endfunction

  task automatic drive(
    input logic v, input logic c, input logic [1:0] kk,
    input logic [15:0] a, input logic [15:0] b, input logic ordy
  );
    in_valid  = v;
    ctrl      = c;
    k         = kk;
    ar        = a;
    ai        = b;
    out_ready = ordy;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        pr !== 16'h0 || pi !== 16'h0) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b pr=%h pi=%h want 0 1 0000 0000",
               out_valid, in_ready, pr, pi);
    end
`ifdef CROT_SAT_NEG_EN
    vectors++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: got %b want 0", sat_flag);
    end
`endif
  endtask

  task automatic test_rotations();
    logic [15:0] er [3];
    logic [15:0] ei [3];
    logic [1:0]  kk;
    logic        ev;
    er = '{16'hFE00, 16'hF000, 16'h0200};
    ei = '{16'h1000, 16'hFE00, 16'hF000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      kk = 2'(c + 1);
      drive(c < 3, 1'b1, kk, 16'h1000, 16'h0200, 1'b1);
      ev = (c >= 3 && c <= 5);
      vectors++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL rot_valid c%0d: got %b want %b", c, out_valid, ev);
      end else if (ev && (pr !== er[c-3] || pi !== ei[c-3])) begin
        errors++;
        $display("FAIL rot_data c%0d: got %h,%h want %h,%h",
                 c, pr, pi, er[c-3], ei[c-3]);
      end
      advance();
    end
  endtask

  task automatic test_identity();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 1'b0, 2'd3, 16'h1234, 16'hABCD, 1'b1);
      if (c == 3) begin
        vectors++;
        if (out_valid !== 1'b1 || pr !== 16'h1234 || pi !== 16'hABCD) begin
          errors++;
          $display("FAIL identity: ov=%b %h,%h want 1 1234,abcd",
                   out_valid, pr, pi);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] da [8];
    logic [15:0] db [8];
    logic [1:0]  dk [8];
    logic [31:0] q [$];
    logic [32:0] r;
    logic [15:0] ppr, ppi;
    logic        ordy, pstall;
    int          sent, got;
    sent = 0; got = 0; pstall = 1'b0; ppr = '0; ppi = '0;
    for (int i = 0; i < 8; i++) begin
      da[i] = 16'($urandom);
      db[i] = 16'($urandom);
      dk[i] = 2'($urandom);
    end
    do_reset();
    for (int c = 0; c < 40 && got < 8; c++) begin
      ordy = !(c >= 4 && c <= 6);
      drive(sent < 8, 1'b1, dk[sent % 8], da[sent % 8], db[sent % 8], ordy);
      if (!ordy) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready c%0d: got %b want 0", c, in_ready);
        end
      end
      if (pstall) begin
        vectors++;
        if (out_valid !== 1'b1 || pr !== ppr || pi !== ppi) begin
          errors++;
          $display("FAIL b2b_hold c%0d: %b %h,%h want 1 %h,%h",
                   c, out_valid, pr, pi, ppr, ppi);
        end
      end
      if (out_valid && ordy) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra c%0d: got %h,%h want none", c, pr, pi);
        end else begin
          if ({pr, pi} !== q[0]) begin
            errors++;
            $display("FAIL b2b_data c%0d: got %h want %h", c, {pr, pi}, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        r = ref_rot(da[sent], db[sent], 1'b1, dk[sent]);
        q.push_back(r[31:0]);
        sent++;
      end
      pstall = out_valid & ~ordy;
      ppr = pr;
      ppi = pi;
      advance();
    end
    vectors++;
    if (got != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d left %0d want 8 0", got, q.size());
    end
  endtask

  task automatic test_neg_min();
    logic [15:0] epr;
`ifdef CROT_SAT_NEG_EN
    epr = 16'h7FFF;
`else
    epr = 16'h8000;
`endif
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 1'b1, 2'd2, 16'h8000, 16'h0000, 1'b1);
      if (c == 3) begin
        vectors++;
        if (out_valid !== 1'b1 || pr !== epr || pi !== 16'h0) begin
          errors++;
          $display("FAIL neg_min: ov=%b %h,%h want 1 %h,0000",
                   out_valid, pr, pi, epr);
        end
      end
`ifdef CROT_SAT_NEG_EN
      if (c == 4) begin
        vectors++;
        if (sat_flag !== 1'b1) begin
          errors++;
          $display("FAIL sat_flag: got %b want 1", sat_flag);
        end
      end
`endif
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1'b1, 1'b1, 2'd1, 16'h0111, 16'h0222, 1'b1);
    advance();
    drive(1'b1, 1'b1, 2'd2, 16'h0333, 16'h0444, 1'b1);
    advance();
    drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL midreset c%0d: ov=%b ov1=%b want 0 0",
                 c, out_valid, out_valid1);
      end
      advance();
    end
  endtask

  task automatic test_latency1();
    do_reset();
    drive(1'b1, 1'b1, 2'd1, 16'h0100, 16'h0001, 1'b1);
    vectors++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_early: got %b want 0", out_valid1);
    end
    advance();
    drive(1'b0, 1'b1, 2'd1, 16'h0, 16'h0, 1'b1);
    vectors++;
    if (out_valid1 !== 1'b1 || pr1 !== 16'hFFFF || pi1 !== 16'h0100) begin
      errors++;
      $display("FAIL lat1: ov=%b %h,%h want 1 ffff,0100",
               out_valid1, pr1, pi1);
    end
    advance();
    vectors++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_after: got %b want 0", out_valid1);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] q [$];
    logic [32:0] r;
    logic [15:0] a, b, ppr, ppi;
    logic [1:0]  kk;
    logic        v, c, ordy, pstall;
    int          got, sent;
    got = 0; sent = 0; pstall = 1'b0; ppr = '0; ppi = '0;
    do_reset();
    for (int n = 0; n < 460; n++) begin
      v    = (n < 400) && ($urandom_range(3) != 0);
      ordy = (n >= 400) || ($urandom_range(2) != 0);
      c    = 1'($urandom);
      kk   = 2'($urandom);
      a    = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
      b    = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
      drive(v, c, kk, a, b, ordy);
      vectors++;
      if (in_ready !== (ordy | ~out_valid)) begin
        errors++;
        $display("FAIL rnd_ready n%0d: got %b want %b",
                 n, in_ready, ordy | ~out_valid);
      end
      if (pstall) begin
        vectors++;
        if (out_valid !== 1'b1 || pr !== ppr || pi !== ppi) begin
          errors++;
          $display("FAIL rnd_hold n%0d: %b %h,%h want 1 %h,%h",
                   n, out_valid, pr, pi, ppr, ppi);
        end
      end
      if (out_valid && ordy) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra n%0d: got %h,%h want none", n, pr, pi);
        end else begin
          if ({pr, pi} !== q[0]) begin
            errors++;
            $display("FAIL rnd_data n%0d: got %h want %h", n, {pr, pi}, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (v && in_ready) begin
        r = ref_rot(a, b, c, kk);
        q.push_back(r[31:0]);
        sent++;
      end
      pstall = out_valid & ~ordy;
      ppr = pr;
      ppi = pi;
      advance();
    end
    vectors++;
    if (q.size() != 0 || got != sent) begin
      errors++;
      $display("FAIL rnd_drain: sent %0d got %0d left %0d want equal 0",
               sent, got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rotations();
    test_identity();
    test_back_to_back();
    test_neg_min();
    test_reset_midstream();
    test_latency1();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
